// File: rtl/five_tap_sampler.sv
// Synchronizes an asynchronous line and, on request, captures five time-spaced samples of it.
// Define FIVE_TAP_SAMPLER_VOTE_EN to add a registered 3-of-5 majority output `vote`.
module five_tap_sampler #(
    parameter int START_DELAY = 2,
    parameter int SPACING     = 4,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic sample_req,
    input  logic out_ready,
    output logic out_valid,
    output logic x1,
    output logic x2,
    output logic x3,
    output logic x4,
    output logic x5,
    output logic busy,
    output logic overrun
`ifdef FIVE_TAP_SAMPLER_VOTE_EN
    ,
    output logic vote
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] START_CNT  = CNT_W'(START_DELAY);
    localparam logic [CNT_W-1:0] RELOAD_CNT = CNT_W'(SPACING - 1);
    localparam logic [2:0]       LAST_IDX   = 3'd4;

`ifdef FIVE_TAP_SAMPLER_VOTE_EN
    function automatic logic maj5(input logic [4:0] v);
        logic [2:0] s;
        s = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]} + {2'b00, v[4]};
        return (s >= 3'd3);
    endfunction
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic             r_sync1;
    logic             r_sync2;
    logic [3:0]       r_samp;
    logic [4:0]       r_x;
    logic             r_valid;
    logic             r_busy;
    logic             r_overrun;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_idx_nxt;
    logic             w_capture;
    logic             w_last;
    logic             w_overrun_nxt;
    logic [3:0]       w_samp_nxt;
    logic [4:0]       w_x_nxt;

    // Two-flop synchronizer for the asynchronous input line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
        end
    end

    // Control state, interval counter and sample index registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= CNT_ZERO;
            r_idx     <= 3'd0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_valid   <= (w_state_nxt == ST_HOLD);
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_overrun <= w_overrun_nxt;
        end
    end

    // Next-state logic: a capture fires whenever the counter has run down to zero.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_capture     = 1'b0;
        w_last        = 1'b0;
        w_overrun_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (sample_req) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = START_CNT;
                    w_idx_nxt   = 3'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT, ST_SAMPLE: begin
                w_overrun_nxt = sample_req;
                if (r_cnt == CNT_ZERO) begin
                    w_capture = 1'b1;
                    w_cnt_nxt = RELOAD_CNT;
                    if (r_idx == LAST_IDX) begin
                        w_last      = 1'b1;
                        w_idx_nxt   = 3'd0;
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_state_nxt = ST_SAMPLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            ST_HOLD: begin
                // A request on the handshake edge is still dropped: the state is HOLD here.
                w_overrun_nxt = sample_req;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = CNT_ZERO;
                w_idx_nxt   = 3'd0;
            end
        endcase
    end

    // Sample datapath: the first four samples wait internally, the fifth loads all outputs at once.
    always_comb begin
        w_samp_nxt = r_samp;
        w_x_nxt    = r_x;
        if (w_capture && !w_last) begin
            w_samp_nxt[r_idx[1:0]] = r_sync2;
        end else begin
            w_samp_nxt = r_samp;
        end
        if (w_last) begin
            w_x_nxt = {r_sync2, r_samp};
        end else begin
            w_x_nxt = r_x;
        end
    end

    // Internal sample store and presented vector.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_samp <= 4'd0;
            r_x    <= 5'd0;
        end else begin
            r_samp <= w_samp_nxt;
            r_x    <= w_x_nxt;
        end
    end

`ifdef FIVE_TAP_SAMPLER_VOTE_EN
    logic r_vote;

    // Majority of the vector, refreshed on the same edge as the vector itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vote <= 1'b0;
        end else if (w_last) begin
            r_vote <= maj5(w_x_nxt);
        end else begin
            r_vote <= r_vote;
        end
    end

    assign vote = r_vote;
`endif

    assign out_valid = r_valid;
    assign busy      = r_busy;
    assign overrun   = r_overrun;
    assign x1        = r_x[0];
    assign x2        = r_x[1];
    assign x3        = r_x[2];
    assign x4        = r_x[3];
    assign x5        = r_x[4];

endmodule

// File: tb/tb_five_tap_sampler.sv
// Self-checking bench: two sampler instances (default timing and tight timing) checked
// against a model that reads the raw din history at the edges where captures must occur.
module tb_five_tap_sampler;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic       req_a, rdy_a, va, busy_a, ovr_a;
    logic       req_b, rdy_b, vb, busy_b, ovr_b;
    logic [4:0] xa, xb;
`ifdef FIVE_TAP_SAMPLER_VOTE_EN
    logic       vote_a, vote_b;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int ecnt     = 0;
    logic hist [int];

    five_tap_sampler #(.START_DELAY(2), .SPACING(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din), .sample_req(req_a), .out_ready(rdy_a),
        .out_valid(va), .x1(xa[0]), .x2(xa[1]), .x3(xa[2]), .x4(xa[3]), .x5(xa[4]),
        .busy(busy_a), .overrun(ovr_a)
`ifdef FIVE_TAP_SAMPLER_VOTE_EN
        , .vote(vote_a)
`endif
    );

    five_tap_sampler #(.START_DELAY(0), .SPACING(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din), .sample_req(req_b), .out_ready(rdy_b),
        .out_valid(vb), .x1(xb[0]), .x2(xb[1]), .x3(xb[2]), .x4(xb[3]), .x5(xb[4]),
        .busy(busy_b), .overrun(ovr_b)
`ifdef FIVE_TAP_SAMPLER_VOTE_EN
        , .vote(vote_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record din for the upcoming edge, pass that edge, settle.
    task automatic step();
        hist[ecnt] = din;
        @(posedge clk);
        ecnt++;
        #1;
    endtask

    // Sample k (0-based) is raw din two edges before capture edge e0+sd+1+k*sp.
    function automatic logic [4:0] model_vec(input int e0, input int sd, input int sp);
        logic [4:0] v;
        for (int k = 0; k < 5; k++) v[k] = hist[e0 + sd + 1 + k * sp - 2];
        return v;
    endfunction

`ifdef FIVE_TAP_SAMPLER_VOTE_EN
    function automatic logic model_maj(input logic [4:0] v);
        int c;
        c = 0;
        for (int k = 0; k < 5; k++) c += int'(v[k]);
        return (c >= 3);
    endfunction
`endif

    task automatic test_reset();
        rst_n = 1'b0; din = 1'b0;
        req_a = 1'b0; rdy_a = 1'b0; req_b = 1'b0; rdy_b = 1'b0;
        repeat (3) step();
        n_checks++; if (va !== 1'b0) $display("FAIL reset_valid_a: got %b want 0", va); else n_pass++;
        n_checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy_a: got %b want 0", busy_a); else n_pass++;
        n_checks++; if (ovr_a !== 1'b0) $display("FAIL reset_ovr_a: got %b want 0", ovr_a); else n_pass++;
        n_checks++; if (xa !== 5'b00000) $display("FAIL reset_x_a: got %b want 00000", xa); else n_pass++;
        n_checks++; if ({vb, busy_b, ovr_b, xb} !== 8'h00) $display("FAIL reset_b: got %b want 0", {vb, busy_b, ovr_b, xb}); else n_pass++;
`ifdef FIVE_TAP_SAMPLER_VOTE_EN
        n_checks++; if ({vote_a, vote_b} !== 2'b00) $display("FAIL reset_vote: got %b want 00", {vote_a, vote_b}); else n_pass++;
`endif
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_steady();
        int e0;
        logic ev;
        din = 1'b1; rdy_a = 1'b0;
        repeat (3) step();
        req_a = 1'b1; e0 = ecnt; step(); req_a = 1'b0;
        n_checks++; if (busy_a !== 1'b1) $display("FAIL steady_busy_start: got %b want 1", busy_a); else n_pass++;
        for (int n = 1; n <= 19; n++) begin
            step();
            ev = (n == 19) ? 1'b1 : 1'b0;
            n_checks++; if (va !== ev) $display("FAIL steady_valid e%0d: got %b want %b", n, va, ev); else n_pass++;
            n_checks++; if (busy_a !== 1'b1) $display("FAIL steady_busy e%0d: got %b want 1", n, busy_a); else n_pass++;
        end
        n_checks++; if (xa !== 5'b11111) $display("FAIL steady_x: got %b want 11111", xa); else n_pass++;
        n_checks++; if (xa !== model_vec(e0, 2, 4)) $display("FAIL steady_x_model: got %b want %b", xa, model_vec(e0, 2, 4)); else n_pass++;
`ifdef FIVE_TAP_SAMPLER_VOTE_EN
        n_checks++; if (vote_a !== 1'b1) $display("FAIL steady_vote: got %b want 1", vote_a); else n_pass++;
`endif
        repeat (10) begin
            din = 1'($urandom);
            step();
            n_checks++; if ({va, busy_a, xa} !== 7'b1111111) $display("FAIL steady_hold: got %b want 1111111", {va, busy_a, xa}); else n_pass++;
        end
        rdy_a = 1'b1; step(); rdy_a = 1'b0;
        n_checks++; if ({va, busy_a} !== 2'b00) $display("FAIL steady_handshake: got %b want 00", {va, busy_a}); else n_pass++;
        n_checks++; if (xa !== 5'b11111) $display("FAIL steady_retain: got %b want 11111", xa); else n_pass++;
    endtask

    task automatic test_glitch();
        int e0;
        logic ev;
        din = 1'b0;
        repeat (3) step();
        req_a = 1'b1; e0 = ecnt; step(); req_a = 1'b0;
        for (int n = 1; n <= 19; n++) begin
            din = (ecnt == e0 + 9) ? 1'b1 : 1'b0;
            step();
            ev = (n == 19) ? 1'b1 : 1'b0;
            n_checks++; if (va !== ev) $display("FAIL glitch_valid e%0d: got %b want %b", n, va, ev); else n_pass++;
        end
        n_checks++; if (xa !== 5'b00100) $display("FAIL glitch_x: got %b want 00100", xa); else n_pass++;
        n_checks++; if (xa !== model_vec(e0, 2, 4)) $display("FAIL glitch_x_model: got %b want %b", xa, model_vec(e0, 2, 4)); else n_pass++;
`ifdef FIVE_TAP_SAMPLER_VOTE_EN
        n_checks++; if (vote_a !== 1'b0) $display("FAIL glitch_vote: got %b want 0", vote_a); else n_pass++;
`endif
        rdy_a = 1'b1; step(); rdy_a = 1'b0;
        n_checks++; if (va !== 1'b0) $display("FAIL glitch_handshake: got %b want 0", va); else n_pass++;
    endtask

    task automatic test_overrun();
        int e0;
        logic ev, eo;
        logic [4:0] exp_x;
        req_a = 1'b1; e0 = ecnt; step(); req_a = 1'b0;
        for (int n = 1; n <= 19; n++) begin
            req_a = (n == 8) ? 1'b1 : 1'b0;
            din = 1'($urandom);
            step();
            ev = (n == 19) ? 1'b1 : 1'b0;
            eo = (n == 8) ? 1'b1 : 1'b0;
            n_checks++; if (ovr_a !== eo) $display("FAIL ovr_sample e%0d: got %b want %b", n, ovr_a, eo); else n_pass++;
            n_checks++; if (va !== ev) $display("FAIL ovr_valid e%0d: got %b want %b", n, va, ev); else n_pass++;
        end
        req_a = 1'b0;
        exp_x = model_vec(e0, 2, 4);
        n_checks++; if (xa !== exp_x) $display("FAIL ovr_x: got %b want %b", xa, exp_x); else n_pass++;
        req_a = 1'b1; step(); req_a = 1'b0;
        n_checks++; if ({ovr_a, va, xa} !== {2'b11, exp_x}) $display("FAIL ovr_hold: got %b want %b", {ovr_a, va, xa}, {2'b11, exp_x}); else n_pass++;
        step();
        n_checks++; if ({ovr_a, va} !== 2'b01) $display("FAIL ovr_hold_clear: got %b want 01", {ovr_a, va}); else n_pass++;
        rdy_a = 1'b1; req_a = 1'b1; step(); rdy_a = 1'b0; req_a = 1'b0;
        n_checks++; if ({va, busy_a, ovr_a} !== 3'b001) $display("FAIL ovr_handshake_req: got %b want 001", {va, busy_a, ovr_a}); else n_pass++;
        n_checks++; if (xa !== exp_x) $display("FAIL ovr_retain: got %b want %b", xa, exp_x); else n_pass++;
        step();
        n_checks++; if ({busy_a, ovr_a} !== 2'b00) $display("FAIL ovr_idle: got %b want 00", {busy_a, ovr_a}); else n_pass++;
        req_a = 1'b1; e0 = ecnt; step(); req_a = 1'b0;
        n_checks++; if ({busy_a, ovr_a} !== 2'b10) $display("FAIL ovr_reaccept: got %b want 10", {busy_a, ovr_a}); else n_pass++;
        for (int n = 1; n <= 19; n++) begin
            din = 1'($urandom);
            step();
            ev = (n == 19) ? 1'b1 : 1'b0;
            n_checks++; if (va !== ev) $display("FAIL ovr_second_valid e%0d: got %b want %b", n, va, ev); else n_pass++;
        end
        n_checks++; if (xa !== model_vec(e0, 2, 4)) $display("FAIL ovr_second_x: got %b want %b", xa, model_vec(e0, 2, 4)); else n_pass++;
        rdy_a = 1'b1; step(); rdy_a = 1'b0;
    endtask

    task automatic test_reset_mid();
        int e0;
        req_a = 1'b1; e0 = ecnt; step(); req_a = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            din = 1'($urandom);
            step();
        end
        rst_n = 1'b0; step(); rst_n = 1'b1;
        n_checks++; if ({va, busy_a, ovr_a, xa} !== 8'h00) $display("FAIL rstmid_outputs: got %b want 0", {va, busy_a, ovr_a, xa}); else n_pass++;
`ifdef FIVE_TAP_SAMPLER_VOTE_EN
        n_checks++; if (vote_a !== 1'b0) $display("FAIL rstmid_vote: got %b want 0", vote_a); else n_pass++;
`endif
        for (int n = 0; n < 30; n++) begin
            din = 1'($urandom);
            step();
            n_checks++; if ({va, busy_a} !== 2'b00) $display("FAIL rstmid_quiet c%0d: got %b want 00", n, {va, busy_a}); else n_pass++;
        end
        n_checks++; if (xa !== 5'b00000) $display("FAIL rstmid_x: got %b want 00000", xa); else n_pass++;
    endtask

    task automatic test_tight();
        int e0;
        logic ev;
        logic [4:0] exp_x;
        rdy_b = 1'b0;
        din = 1'b1; step();
        din = 1'b0; req_b = 1'b1; e0 = ecnt; step(); req_b = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            if (n == 1 || n == 3) din = 1'b1;
            else if (n == 2) din = 1'b0;
            else din = 1'($urandom);
            step();
            ev = (n == 5) ? 1'b1 : 1'b0;
            n_checks++; if (vb !== ev) $display("FAIL tight_valid e%0d: got %b want %b", n, vb, ev); else n_pass++;
        end
        n_checks++; if (xb !== 5'b10101) $display("FAIL tight_x: got %b want 10101", xb); else n_pass++;
        n_checks++; if (xb !== model_vec(e0, 0, 1)) $display("FAIL tight_x_model: got %b want %b", xb, model_vec(e0, 0, 1)); else n_pass++;
`ifdef FIVE_TAP_SAMPLER_VOTE_EN
        n_checks++; if (vote_b !== 1'b1) $display("FAIL tight_vote: got %b want 1", vote_b); else n_pass++;
`endif
        rdy_b = 1'b1; step();
        n_checks++; if ({vb, busy_b} !== 2'b00) $display("FAIL tight_handshake: got %b want 00", {vb, busy_b}); else n_pass++;
        repeat (4) begin
            req_b = 1'b1; e0 = ecnt; step(); req_b = 1'b0;
            n_checks++; if ({busy_b, ovr_b} !== 2'b10) $display("FAIL tight_accept: got %b want 10", {busy_b, ovr_b}); else n_pass++;
            for (int n = 1; n <= 5; n++) begin
                din = 1'($urandom);
                step();
                ev = (n == 5) ? 1'b1 : 1'b0;
                n_checks++; if (vb !== ev) $display("FAIL tight_b2b_valid e%0d: got %b want %b", n, vb, ev); else n_pass++;
            end
            exp_x = model_vec(e0, 0, 1);
            n_checks++; if (xb !== exp_x) $display("FAIL tight_b2b_x: got %b want %b", xb, exp_x); else n_pass++;
`ifdef FIVE_TAP_SAMPLER_VOTE_EN
            n_checks++; if (vote_b !== model_maj(exp_x)) $display("FAIL tight_b2b_vote: got %b want %b", vote_b, model_maj(exp_x)); else n_pass++;
`endif
            step();
            n_checks++; if ({vb, busy_b, ovr_b} !== 3'b000) $display("FAIL tight_b2b_done: got %b want 000", {vb, busy_b, ovr_b}); else n_pass++;
        end
        rdy_b = 1'b0;
    endtask

    task automatic test_back_to_back();
        int e0;
        logic ev;
        logic [4:0] exp_x;
        rdy_a = 1'b1;
        req_a = 1'b1; e0 = ecnt; step(); req_a = 1'b0;
        repeat (3) begin
            for (int n = 1; n <= 19; n++) begin
                din = 1'($urandom);
                step();
                ev = (n == 19) ? 1'b1 : 1'b0;
                n_checks++; if (va !== ev) $display("FAIL b2b_valid e%0d: got %b want %b", n, va, ev); else n_pass++;
                n_checks++; if (ovr_a !== 1'b0) $display("FAIL b2b_ovr e%0d: got %b want 0", n, ovr_a); else n_pass++;
            end
            exp_x = model_vec(e0, 2, 4);
            n_checks++; if (xa !== exp_x) $display("FAIL b2b_x: got %b want %b", xa, exp_x); else n_pass++;
`ifdef FIVE_TAP_SAMPLER_VOTE_EN
            n_checks++; if (vote_a !== model_maj(exp_x)) $display("FAIL b2b_vote: got %b want %b", vote_a, model_maj(exp_x)); else n_pass++;
`endif
            step();
            n_checks++; if ({va, busy_a} !== 2'b00) $display("FAIL b2b_one_cycle: got %b want 00", {va, busy_a}); else n_pass++;
            req_a = 1'b1; e0 = ecnt; step(); req_a = 1'b0;
            n_checks++; if ({busy_a, ovr_a} !== 2'b10) $display("FAIL b2b_accept: got %b want 10", {busy_a, ovr_a}); else n_pass++;
        end
        rdy_a = 1'b0;
    endtask

    initial begin
        test_reset();
        test_steady();
        test_glitch();
        test_overrun();
        test_reset_mid();
        test_tight();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
